// File: rtl/fault_event_logger.sv
// Fault event logger: edge-detects ECC/ALU fault flags, queues {mask, ts, result} entries
// in a show-ahead FIFO and keeps saturating counters. Optional irq output: FAULT_LOG_IRQ_EN.
module fault_event_logger #(
    parameter int DEPTH      = 8,
    parameter int TS_W       = 16,
    parameter int CNT_W      = 8,
    parameter int IRQ_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_err_imem,
    input  logic                   d_err_imem,
    input  logic                   s_err_dmem,
    input  logic                   d_err_dmem,
    input  logic                   alu_fault_in,
    input  logic [31:0]            resultw_in,
    input  logic                   clr_cnt,
    input  logic                   log_ready,
    output logic                   log_valid,
    output logic [5+TS_W+32-1:0]   log_data,
    output logic [CNT_W-1:0]       sec_cnt,
    output logic [CNT_W-1:0]       ded_cnt,
    output logic [CNT_W-1:0]       alu_cnt,
    output logic                   overflow,
`ifdef FAULT_LOG_IRQ_EN
    output logic                   irq,
`endif
    output logic                   fatal
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 5 + TS_W + 32;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [4:0]         flags, prev, rise;
    logic [TS_W-1:0]    ts;
    logic [AW:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic               empty, full, push_req, pop, do_push, drop, severe;
    logic [1:0]         sec_inc, ded_inc, alu_inc;
    logic [CNT_W-1:0]   sec_nxt, ded_nxt, alu_nxt;
    logic               overflow_nxt, fatal_nxt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign flags    = {alu_fault_in, d_err_dmem, s_err_dmem, d_err_imem, s_err_imem};
    assign rise     = flags & ~prev;
    assign push_req = |rise;
    assign severe   = rise[1] | rise[3] | rise[4];

    // Full/empty from the extra wrap bit of each pointer.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ~empty & log_ready;
    assign do_push  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign log_valid = ~empty;
    assign log_data  = log_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_comb begin
        sec_inc      = {1'b0, rise[0]} + {1'b0, rise[2]};
        ded_inc      = {1'b0, rise[1]} + {1'b0, rise[3]};
        alu_inc      = {1'b0, rise[4]};
        // Clear takes effect first so a same-cycle event is counted on top of zero.
        sec_nxt      = sat_add(clr_cnt ? '0 : sec_cnt, sec_inc);
        ded_nxt      = sat_add(clr_cnt ? '0 : ded_cnt, ded_inc);
        alu_nxt      = sat_add(clr_cnt ? '0 : alu_cnt, alu_inc);
        overflow_nxt = (overflow & ~clr_cnt) | drop;
        fatal_nxt    = (fatal & ~clr_cnt) | severe;
        wr_ptr_nxt   = wr_ptr + (AW+1)'(do_push);
        rd_ptr_nxt   = rd_ptr + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {rise, ts, resultw_in};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sec_cnt  <= '0;
            ded_cnt  <= '0;
            alu_cnt  <= '0;
            overflow <= 1'b0;
            fatal    <= 1'b0;
        end else begin
            prev     <= flags;
            ts       <= ts + 1'b1;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            sec_cnt  <= sec_nxt;
            ded_cnt  <= ded_nxt;
            alu_cnt  <= alu_nxt;
            overflow <= overflow_nxt;
            fatal    <= fatal_nxt;
        end
    end

`ifdef FAULT_LOG_IRQ_EN
    localparam logic [AW:0] IRQ_LVL = IRQ_THRESH[AW:0];
    logic [AW:0] occ_nxt;
    assign occ_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // Registered from next-state values so irq tracks the occupancy seen on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= (occ_nxt >= IRQ_LVL) | fatal_nxt;
    end
`endif

endmodule
